seq_end_selector: RTL and testbench
===================================

// Module: seq_end_selector
// PURPOSE
//   Parametrised, registered successor to the combinational sequence-end mux.
//   Selects one of NUM_CH audio-sequence end signals by audio_select, rising-edge detects it and
//   emits a 1-cycle end pulse plus a sticky done flag cleared by ack. Masks glitches across
//   select changes, flags overruns and counts completed sequences. Sits between the per-sequence
//   players and the playback control FSM.
// PARAMETERS
//   NUM_CH      8  number of seq_end inputs (channel index = select value)
//   SEL_W       3  width of audio_select; 2**SEL_W >= NUM_CH
//   FIRST_VALID 2  lowest select value with a sequence; lower values behave as "no sequence"
//   SETTLE_CYC  4  cycles edges are ignored after reset or any select change (>=1)
//   CNT_W       8  width of end_count
// PORTS
//   clk           in   1        system clock; all logic on rising edge
//   reset         in   1        synchronous, active-high reset
//   audio_select  in   SEL_W    selected sequence number
//   seq_end       in   NUM_CH   per-channel end level/pulse, bit i = sequence i
//   ack           in   1        consumer acknowledge; clears seq_end_flag/overrun
//   seq_end_pulse out  1        1-cycle pulse per detected end on selected channel
//   seq_end_flag  out  1        sticky end flag, held until ack
//   overrun       out  1        second end seen while flag still set, held until ack
//   sel_valid     out  1        1 when FIRST_VALID <= sel_q < NUM_CH
//   end_count     out  CNT_W    completed ends since last select change (saturating)
// BEHAVIOUR
//   - Reset: all outputs 0; s_q=s_qq=0; sel_q<=audio_select; state SETTLE, settle_cnt=SETTLE_CYC.
//   - seq_end registered twice (s_q, s_qq); edge = s_q[sel_q] & ~s_qq[sel_q].
//     Input first sampled high at edge k -> seq_end_pulse high for the cycle after edge k+1.
//   - Select change (audio_select != sel_q), any state, highest priority: sel_q<=audio_select,
//     flag/overrun/end_count <= 0, pulse suppressed, -> SETTLE with settle_cnt=SETTLE_CYC.
//   - States:
//     SETTLE: decrement settle_cnt; edges ignored; at settle_cnt==1 -> ARMED if sel_valid else IDLE.
//     IDLE  : invalid select; edges ignored; outputs hold 0 except sel_valid=0.
//     ARMED : edge -> pulse, flag<=1, end_count++, -> DONE. ack alone: no effect.
//     DONE  : ack & !edge -> flag,overrun <= 0, -> ARMED.
//             edge & !ack -> pulse, end_count++, overrun<=1, stay DONE.
//             edge & ack  -> pulse, end_count++, flag stays 1, overrun<=0, stay DONE.
//   - end_count saturates at 2**CNT_W-1; no wrap.
//   - seq_end held high produces one pulse only; a new pulse needs a low sample first.
//   - Select values >= NUM_CH or < FIRST_VALID: IDLE, sel_valid=0, no pulses.
//   - Reset mid-operation: in-progress flag/count discarded; resumes via SETTLE.
// CONFIGURATION
//   SEQ_END_COUNT_EN defined  : end_count counter implemented as above.
//   SEQ_END_COUNT_EN undefined: no counter logic; end_count tied to 0; all else identical.
// TESTING
//   1 reset, sel=3, seq_end[3] rises after SETTLE -> one pulse 2 clk after first sample,
//     flag=1, end_count=1; ack -> flag=0 next cycle, state ARMED.
//   2 sel=1 (below FIRST_VALID) and sel=9 with NUM_CH=8 (SEL_W=4): toggle all seq_end
//     -> sel_valid=0, no pulse, flag=0.
//   3 seq_end[4] rises 2 cycles after sel changes 2->4 (within SETTLE_CYC=4) -> no pulse;
//     flag and end_count 0 after change.
//   4 two ends on ch 5 without ack -> 2 pulses, flag=1, overrun=1, end_count=2;
//     edge coincident with ack -> pulse, flag=1, overrun=0.
//   5 CNT_W=2, 5 ends with acks -> end_count sequence 1,2,3,3,3.
//     Rebuild without SEQ_END_COUNT_EN -> end_count stays 0.
//   6 assert reset while in DONE -> all outputs 0 next cycle; SETTLE replayed before ARMED.

Source files
------------

// File: rtl/seq_end_selector.sv
`default_nettype none
// ============================================================================
// Module   : seq_end_selector
// Purpose  : Registered selector for per-sequence "end" signals. Picks the
//            channel addressed by audio_select, rising-edge detects it and
//            reports a 1-cycle end pulse, a sticky done flag (cleared by
//            ack), an overrun flag and a saturating count of completed ends.
//            Edges are masked for SETTLE_CYC cycles after reset or any
//            select change so switching sequences cannot raise a false end.
// Ports    : clk           - system clock, rising edge
//            reset         - synchronous, active-high reset
//            audio_select  - [SEL_W] selected sequence number
//            seq_end       - [NUM_CH] per-channel end level/pulse
//            ack           - consumer acknowledge, clears flag/overrun
//            seq_end_pulse - 1-cycle pulse per detected end
//            seq_end_flag  - sticky end flag, held until ack
//            overrun       - second end while flag set, held until ack
//            sel_valid     - FIRST_VALID <= selected channel < NUM_CH
//            end_count     - [CNT_W] ends since last select change
// Config   : define SEQ_END_COUNT_EN to build the end_count counter;
//            otherwise end_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_end_selector #(
  parameter int NUM_CH      = 8,
  parameter int SEL_W       = 3,
  parameter int FIRST_VALID = 2,
  parameter int SETTLE_CYC  = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  audio_select,
  input  logic [NUM_CH-1:0] seq_end,
  input  logic              ack,
  output logic              seq_end_pulse,
  output logic              seq_end_flag,
  output logic              overrun,
  output logic              sel_valid,
  output logic [CNT_W-1:0]  end_count
);

  localparam int c_SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_INIT = c_SETTLE_W'(SETTLE_CYC);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(1);

  localparam logic [1:0] c_SETTLE = 2'd0;
  localparam logic [1:0] c_IDLE   = 2'd1;
  localparam logic [1:0] c_ARMED  = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  logic [NUM_CH-1:0]     r_sQ;
  logic [NUM_CH-1:0]     r_sQQ;
  logic [SEL_W-1:0]      r_selQ;
  logic [1:0]            r_state;
  logic [c_SETTLE_W-1:0] r_settleCnt;
  logic                  r_pulse;
  logic                  r_flag;
  logic                  r_overrun;
  logic                  r_selValid;

  logic w_edge;
  logic w_selChange;
  logic w_accept;

  function automatic logic isValid(input logic [SEL_W-1:0] s);
    return (32'(s) >= 32'(FIRST_VALID)) && (32'(s) < 32'(NUM_CH));
  endfunction

  // Out-of-range select values never match a channel, so no edge is seen.
  always_comb begin
    w_edge = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (32'(r_selQ) == 32'(i)) begin
        w_edge = r_sQ[i] & ~r_sQQ[i];
      end
    end
  end

  assign w_selChange = (audio_select != r_selQ);
  // An edge only counts when armed or done and no select change is pending.
  assign w_accept    = w_edge && !w_selChange &&
                       ((r_state == c_ARMED) || (r_state == c_DONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sQ        <= '0;
      r_sQQ       <= '0;
      r_selQ      <= audio_select;
      r_state     <= c_SETTLE;
      r_settleCnt <= c_SETTLE_INIT;
      r_pulse     <= 1'b0;
      r_flag      <= 1'b0;
      r_overrun   <= 1'b0;
      r_selValid  <= 1'b0;
    end else begin
      r_sQ    <= seq_end;
      r_sQQ   <= r_sQ;
      r_pulse <= w_accept;
      if (w_selChange) begin
        r_selQ      <= audio_select;
        r_flag      <= 1'b0;
        r_overrun   <= 1'b0;
        r_state     <= c_SETTLE;
        r_settleCnt <= c_SETTLE_INIT;
        r_selValid  <= isValid(audio_select);
      end else begin
        r_selValid <= isValid(r_selQ);
        case (r_state)
          c_SETTLE: begin
            if (r_settleCnt == c_SETTLE_LAST) begin
              r_state <= isValid(r_selQ) ? c_ARMED : c_IDLE;
            end else begin
              r_settleCnt <= r_settleCnt - c_SETTLE_LAST;
            end
          end
          c_ARMED: begin
            if (w_edge) begin
              r_flag  <= 1'b1;
              r_state <= c_DONE;
            end
          end
          c_DONE: begin
            if (w_edge) begin
              // Coincident ack consumes the old end; the new one keeps flag set.
              r_overrun <= !ack;
            end else if (ack) begin
              r_flag    <= 1'b0;
              r_overrun <= 1'b0;
              r_state   <= c_ARMED;
            end
          end
          default: begin
            r_state <= c_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SEQ_END_COUNT_EN
  logic [CNT_W-1:0] r_endCount;

  always_ff @(posedge clk) begin
    if (reset || w_selChange) begin
      r_endCount <= '0;
    end else if (w_accept && (r_endCount != {CNT_W{1'b1}})) begin
      r_endCount <= r_endCount + CNT_W'(1);
    end
  end

  assign end_count = r_endCount;
`else
  assign end_count = '0;
`endif

  assign seq_end_pulse = r_pulse;
  assign seq_end_flag  = r_flag;
  assign overrun       = r_overrun;
  assign sel_valid     = r_selValid;

endmodule
`default_nettype wire

// File: tb/tb_seq_end_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_end_selector
// Purpose  : Self-checking bench for seq_end_selector (NUM_CH=8, SEL_W=4,
//            FIRST_VALID=2, SETTLE_CYC=4, CNT_W=2). A table of per-cycle
//            input/expected-output records is applied first, followed by
//            hand-written sequences for counter saturation and reset in DONE.
//            Expected end_count is zero unless SEQ_END_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_end_selector;

  logic       clk;
  logic       reset;
  logic [3:0] audio_select;
  logic [7:0] seq_end;
  logic       ack;
  logic       seq_end_pulse;
  logic       seq_end_flag;
  logic       overrun;
  logic       sel_valid;
  logic [1:0] end_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic [3:0] sel;
    logic [7:0] se;
    logic       ack;
    logic       p;
    logic       f;
    logic       o;
    logic       v;
    logic [1:0] c;
  } vec_t;

  vec_t vecs[$];

  seq_end_selector #(
    .NUM_CH     (8),
    .SEL_W      (4),
    .FIRST_VALID(2),
    .SETTLE_CYC (4),
    .CNT_W      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_select (audio_select),
    .seq_end      (seq_end),
    .ack          (ack),
    .seq_end_pulse(seq_end_pulse),
    .seq_end_flag (seq_end_flag),
    .overrun      (overrun),
    .sel_valid    (sel_valid),
    .end_count    (end_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] expCnt(input logic [1:0] c);
`ifdef SEQ_END_COUNT_EN
    return c;
`else
    return 2'd0;
`endif
  endfunction

  function automatic void add(input logic rst, input logic [3:0] sel,
                              input logic [7:0] se, input logic a,
                              input logic p, input logic f, input logic o,
                              input logic v, input logic [1:0] c);
    vec_t r;
    r.rst = rst; r.sel = sel; r.se = se; r.ack = a;
    r.p = p; r.f = f; r.o = o; r.v = v; r.c = c;
    vecs.push_back(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic p, input logic f,
                       input logic o, input logic v, input logic [1:0] c);
    logic [5:0] act;
    logic [5:0] exp;
    act = {seq_end_pulse, seq_end_flag, overrun, sel_valid, end_count};
    exp = {p, f, o, v, expCnt(c)};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got pulse/flag/ovr/valid/cnt=%b required %b", name, act, exp);
    end
  endtask

  initial begin
    reset        = 1'b1;
    audio_select = 4'd3;
    seq_end      = 8'h00;
    ack          = 1'b0;

    // Basic end on channel 3, ack, re-arm and held-high single pulse.
    add(1, 3, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 3, 8'h00, 0, 0, 0, 0, 1, 0);
    add(0, 3, 8'h08, 0, 0, 0, 0, 1, 0);
    add(0, 3, 8'h08, 0, 1, 1, 0, 1, 1);
    add(0, 3, 8'h08, 1, 0, 0, 0, 1, 1);
    add(0, 3, 8'h00, 0, 0, 0, 0, 1, 1);
    add(0, 3, 8'h08, 0, 0, 0, 0, 1, 1);
    add(0, 3, 8'h08, 0, 1, 1, 0, 1, 2);
    add(0, 3, 8'h08, 0, 0, 1, 0, 1, 2);
    add(0, 3, 8'h08, 0, 0, 1, 0, 1, 2);
    // Select change clears flag/count; edge during settle is masked.
    for (int i = 0; i < 5; i++) add(0, 2, 8'h00, 0, 0, 0, 0, 1, 0);
    add(0, 4, 8'h00, 0, 0, 0, 0, 1, 0);
    add(0, 4, 8'h00, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 4, 8'h10, 0, 0, 0, 0, 1, 0);
    add(0, 4, 8'h00, 0, 0, 0, 0, 1, 0);
    // Invalid selects: below FIRST_VALID and above NUM_CH.
    add(0, 1, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 1, (i % 2 == 0) ? 8'hFF : 8'h00, 0, 0, 0, 0, 0, 0);
    add(0, 9, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 9, (i % 2 == 0) ? 8'hFF : 8'h00, 0, 0, 0, 0, 0, 0);
    // Overrun on channel 5, then edge coincident with ack.
    for (int i = 0; i < 6; i++) add(0, 5, 8'h00 | ((i == 5) ? 8'h20 : 8'h00), 0, 0, 0, 0, 1, 0);
    add(0, 5, 8'h20, 0, 1, 1, 0, 1, 1);
    add(0, 5, 8'h00, 0, 0, 1, 0, 1, 1);
    add(0, 5, 8'h20, 0, 0, 1, 0, 1, 1);
    add(0, 5, 8'h20, 0, 1, 1, 1, 1, 2);
    add(0, 5, 8'h00, 0, 0, 1, 1, 1, 2);
    add(0, 5, 8'h20, 0, 0, 1, 1, 1, 2);
    add(0, 5, 8'h20, 1, 1, 1, 0, 1, 3);
    add(0, 5, 8'h00, 0, 0, 1, 0, 1, 3);
    add(0, 5, 8'h00, 1, 0, 0, 0, 1, 3);

    foreach (vecs[i]) begin
      reset        = vecs[i].rst;
      audio_select = vecs[i].sel;
      seq_end      = vecs[i].se;
      ack          = vecs[i].ack;
      step();
      check($sformatf("row%0d", i), vecs[i].p, vecs[i].f, vecs[i].o, vecs[i].v, vecs[i].c);
    end
    ack = 1'b0;

    // Counter saturation with CNT_W=2: five acked ends on channel 6.
    begin
      logic [1:0] cntExp [5];
      cntExp[0] = 2'd1; cntExp[1] = 2'd2; cntExp[2] = 2'd3;
      cntExp[3] = 2'd3; cntExp[4] = 2'd3;
      audio_select = 4'd6;
      seq_end      = 8'h00;
      step();
      check("sat_change", 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 5; i++) begin
        seq_end = 8'h40;
        step();
        check($sformatf("sat_pre%0d", i), 0, 0, 0, 1, (i == 0) ? 2'd0 : cntExp[i-1]);
        step();
        check($sformatf("sat_end%0d", i), 1, 1, 0, 1, cntExp[i]);
        seq_end = 8'h00;
        ack     = 1'b1;
        step();
        check($sformatf("sat_ack%0d", i), 0, 0, 0, 1, cntExp[i]);
        ack = 1'b0;
      end
    end

    // Reset while in DONE, then the settle window is replayed.
    seq_end = 8'h40;
    step();
    step();
    check("rst_done_pre", 1, 1, 0, 1, 3);
    reset = 1'b1;
    step();
    check("rst_done_clear", 0, 0, 0, 0, 0);
    reset = 1'b0;
    step();
    check("rst_settle1", 0, 0, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      step();
      check($sformatf("rst_settle%0d", i), 0, 0, 0, 1, 0);
    end
    seq_end = 8'h00;
    step();
    check("rst_armed_low", 0, 0, 0, 1, 0);
    seq_end = 8'h40;
    step();
    step();
    check("rst_armed_end", 1, 1, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
